// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared constants for the brew controller and vending FSM
package vm_pkg;

  // Phase FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRIND = 3'd1;
  localparam logic [2:0] ST_HEAT  = 3'd2;
  localparam logic [2:0] ST_POUR  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Default phase lengths in cycles
  localparam int DEF_GRIND_CYC = 4;
  localparam int DEF_HEAT_CYC  = 6;
  localparam int DEF_POUR_CYC  = 8;

  // Water level width, shared with the vending FSM
  localparam int WATER_W = 5;
  // Bean dose counter and phase counter widths
  localparam int DOSE_W  = 8;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/vm_inventory.sv
// rtl/vm_inventory.sv - water tank and bean dose bookkeeping
module vm_inventory
  import vm_pkg::*;
#(
  parameter int WATER_PER_CUP = 2,
  parameter int WATER_MAX     = 31,
  parameter int DOSE_MAX      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refill_water,
  input  logic               refill_beans,
  input  logic               take_dose,
  input  logic               take_water,
  output logic [WATER_W-1:0] water,
  output logic               beans,
  output logic               sufficient
);

  logic [DOSE_W-1:0]  dose;
  logic [DOSE_W-1:0]  dose_n;
  logic [WATER_W-1:0] water_n;

  // Enough inventory for one more cup, judged on the current registers
  assign sufficient = (water >= WATER_W'(WATER_PER_CUP)) && (dose != '0);

  // Next inventory values; callers only assert take_dose when a dose exists,
  // and water subtraction clamps at zero instead of wrapping
  always_comb begin
    water_n = water;
    dose_n  = dose;
    if (refill_water)
      water_n = WATER_W'(WATER_MAX);
    if (take_water)
      water_n = (water >= WATER_W'(WATER_PER_CUP)) ? water - WATER_W'(WATER_PER_CUP) : '0;
    if (refill_beans)
      dose_n = DOSE_W'(DOSE_MAX);
    if (take_dose)
      dose_n = dose - 1'b1;
  end

  // Inventory registers; beans follows the next dose so the last dose clears it on the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      water <= '0;
      dose  <= '0;
      beans <= 1'b0;
    end else begin
      water <= water_n;
      dose  <= dose_n;
      beans <= (dose_n != '0);
    end
  end

endmodule

// File: rtl/vm_brew_ctrl.sv
// rtl/vm_brew_ctrl.sv - grind/heat/pour sequencer with inventory feedback
module vm_brew_ctrl
  import vm_pkg::*;
#(
  parameter int GRIND_CYC     = DEF_GRIND_CYC,
  parameter int HEAT_CYC      = DEF_HEAT_CYC,
  parameter int POUR_CYC      = DEF_POUR_CYC,
  parameter int WATER_PER_CUP = 2,
  parameter int WATER_MAX     = 31,
  parameter int DOSE_MAX      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coffee,
  input  logic               refill_water,
  input  logic               refill_beans,
  output logic [WATER_W-1:0] water,
  output logic               beans,
  output logic               busy,
  output logic               grinder,
  output logic               heater,
  output logic               pump,
  output logic               done,
  output logic               dropped
);

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             idle;
  logic             any_refill;
  logic             sufficient;
  logic             accept;
  logic             drop;
  logic             pour_exit;

  assign idle       = (state == ST_IDLE);
  assign any_refill = refill_water | refill_beans;
  // A refill in the same cycle always wins over a cup request
  assign accept     = idle & coffee & ~any_refill & sufficient;
  assign drop       = coffee & ~accept;
  assign pour_exit  = (state == ST_POUR) && (cnt == '0);

  vm_inventory #(
    .WATER_PER_CUP (WATER_PER_CUP),
    .WATER_MAX     (WATER_MAX),
    .DOSE_MAX      (DOSE_MAX)
  ) u_inventory (
    .clk          (clk),
    .rst          (rst),
    .refill_water (idle & refill_water),
    .refill_beans (idle & refill_beans),
    .take_dose    (accept),
    .take_water   (pour_exit),
    .water        (water),
    .beans        (beans),
    .sufficient   (sufficient)
  );

  // Next state and phase counter: each phase counts down to zero, then loads the next length
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_GRIND;
          cnt_n   = CNT_W'(GRIND_CYC - 1);
        end
      end
      ST_GRIND: begin
        if (cnt == '0) begin
          state_n = ST_HEAT;
          cnt_n   = CNT_W'(HEAT_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_HEAT: begin
        if (cnt == '0) begin
          state_n = ST_POUR;
          cnt_n   = CNT_W'(POUR_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_POUR: begin
        if (cnt == '0) begin
          state_n = ST_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered output decode taken from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      grinder <= 1'b0;
      heater  <= 1'b0;
      pump    <= 1'b0;
      done    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      busy    <= (state_n != ST_IDLE);
      grinder <= (state_n == ST_GRIND);
      heater  <= (state_n == ST_HEAT);
      pump    <= (state_n == ST_POUR);
      done    <= (state_n == ST_DONE);
      dropped <= drop;
    end
  end

endmodule

// File: tb/tb_vm_brew_ctrl.sv
// tb/tb_vm_brew_ctrl.sv - randomized and directed checks against a cup-timeline model
module tb_vm_brew_ctrl;

  localparam int G    = 4;
  localparam int H    = 6;
  localparam int P    = 8;
  localparam int WPC  = 2;
  localparam int WMAX = 30;
  localparam int DMAX = 10;
  localparam int BREW = G + H + P;

  logic       clk;
  logic       rst;
  logic       coffee;
  logic       refill_water;
  logic       refill_beans;
  logic [4:0] water;
  logic       beans;
  logic       busy;
  logic       grinder;
  logic       heater;
  logic       pump;
  logic       done;
  logic       dropped;
  logic [11:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: inventory as integers, brew progress as cycles elapsed since accept (-1 = idle)
  int m_water = 0;
  int m_dose  = 0;
  int m_t     = -1;
  bit m_drop  = 0;

  vm_brew_ctrl #(
    .GRIND_CYC     (G),
    .HEAT_CYC      (H),
    .POUR_CYC      (P),
    .WATER_PER_CUP (WPC),
    .WATER_MAX     (WMAX),
    .DOSE_MAX      (DMAX)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .coffee       (coffee),
    .refill_water (refill_water),
    .refill_beans (refill_beans),
    .water        (water),
    .beans        (beans),
    .busy         (busy),
    .grinder      (grinder),
    .heater       (heater),
    .pump         (pump),
    .done         (done),
    .dropped      (dropped)
  );

  assign obs = {water, beans, busy, grinder, heater, pump, done, dropped};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] exp_vec();
    logic g, h, p, d;
    g = (m_t >= 0) && (m_t < G);
    h = (m_t >= G) && (m_t < G + H);
    p = (m_t >= G + H) && (m_t < BREW);
    d = (m_t == BREW);
    return {5'(m_water), (m_dose > 0), (m_t >= 0), g, h, p, d, m_drop};
  endfunction

  task automatic tick(input bit c, input bit rw, input bit rb, input bit r);
    bit ok;
    coffee       = c;
    refill_water = rw;
    refill_beans = rb;
    rst          = r;
    @(posedge clk);
    if (r) begin
      m_water = 0;
      m_dose  = 0;
      m_t     = -1;
      m_drop  = 0;
    end else if (m_t >= 0) begin
      m_drop = c;
      m_t++;
      if (m_t == BREW)
        m_water = (m_water >= WPC) ? m_water - WPC : 0;
      if (m_t > BREW)
        m_t = -1;
    end else begin
      ok     = c && !rw && !rb && (m_water >= WPC) && (m_dose > 0);
      m_drop = c && !ok;
      if (rw) m_water = WMAX;
      if (rb) m_dose = DMAX;
      if (ok) begin
        m_dose--;
        m_t = 0;
      end
    end
    #1;
  endtask

  task automatic cup();
    tick(1, 0, 0, 0);
    repeat (BREW + 1) tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) begin
      tick(0, 0, 0, 1);
      n_checks++;
      if (obs !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_state: got %h expected %h", obs, 12'h000);
      end
    end
    tick(1, 0, 0, 0);
    n_checks++;
    if (dropped !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: dropped=%b busy=%b expected dropped=1 busy=0", dropped, busy);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_drop_pulse: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_full_brew();
    int ng, nh, np, nd, nb;
    ng = 0; nh = 0; np = 0; nd = 0; nb = 0;
    tick(0, 1, 1, 0);
    n_checks++;
    if (water !== 5'(WMAX) || beans !== 1'b1) begin
      n_fail++;
      $display("FAIL brew_refill: water=%0d beans=%b expected water=%0d beans=1", water, beans, WMAX);
    end
    tick(1, 0, 0, 0);
    for (int i = 0; i < BREW + 6; i++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL brew_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
      ng += grinder; nh += heater; np += pump; nd += done; nb += busy;
      tick(0, 0, 0, 0);
    end
    n_checks++;
    if (ng != G || nh != H || np != P || nd != 1 || nb != BREW + 1) begin
      n_fail++;
      $display("FAIL brew_phase_lengths: got g%0d h%0d p%0d d%0d b%0d expected g%0d h%0d p%0d d1 b%0d",
               ng, nh, np, nd, nb, G, H, P, BREW + 1);
    end
    n_checks++;
    if (water !== 5'(WMAX - WPC) || beans !== 1'b1 || m_dose != DMAX - 1) begin
      n_fail++;
      $display("FAIL brew_inventory: water=%0d beans=%b expected water=%0d beans=1", water, beans, WMAX - WPC);
    end
  endtask

  task automatic test_busy_drop();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 40 && heater !== 1'b1; i++) tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    n_checks++;
    if (dropped !== 1'b1 || water !== 5'(WMAX) || heater !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_drop: dropped=%b water=%0d heater=%b expected 1 %0d 1", dropped, water, heater, WMAX);
    end
    for (int i = 0; i < BREW + 4; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL busy_drop_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (water !== 5'(WMAX - WPC) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_drop_end: water=%0d busy=%b expected %0d 0", water, busy, WMAX - WPC);
    end
  endtask

  task automatic test_last_dose();
    tick(0, 0, 0, 1);
    tick(0, 1, 1, 0);
    repeat (5) cup();
    tick(0, 0, 1, 0);
    repeat (9) cup();
    n_checks++;
    if (water !== 5'(WPC) || beans !== 1'b1 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL last_dose_setup: water=%0d beans=%b expected water=%0d beans=1", water, beans, WPC);
    end
    tick(1, 0, 0, 0);
    n_checks++;
    if (beans !== 1'b0 || grinder !== 1'b1) begin
      n_fail++;
      $display("FAIL last_dose_accept: beans=%b grinder=%b expected 0 1", beans, grinder);
    end
    repeat (BREW + 1) tick(0, 0, 0, 0);
    n_checks++;
    if (water !== 5'd0 || busy !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL last_dose_empty: water=%0d busy=%b expected 0 0", water, busy);
    end
    tick(1, 0, 0, 0);
    n_checks++;
    if (dropped !== 1'b1 || grinder !== 1'b0) begin
      n_fail++;
      $display("FAIL last_dose_reject: dropped=%b grinder=%b expected 1 0", dropped, grinder);
    end
  endtask

  task automatic test_reset_mid_pour();
    int np;
    np = 0;
    tick(0, 1, 1, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 40 && np < 3; i++) begin
      tick(0, 0, 0, 0);
      np += pump;
    end
    tick(0, 0, 0, 1);
    n_checks++;
    if (np != 3 || obs !== 12'h000 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_pour: got %h after %0d pour cycles expected 000 after 3", obs, np);
    end
  endtask

  task automatic test_refill_coffee_same();
    tick(0, 0, 0, 1);
    tick(1, 1, 0, 0);
    n_checks++;
    if (water !== 5'(WMAX) || dropped !== 1'b1 || grinder !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_coffee: water=%0d dropped=%b grinder=%b busy=%b expected %0d 1 0 0",
               water, dropped, grinder, busy, WMAX);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (obs !== exp_vec() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_coffee_after: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    bit c, rw, rb, r;
    for (int i = 0; i < 3000; i++) begin
      c  = ($urandom_range(0, 3) == 0);
      rw = ($urandom_range(0, 15) == 0);
      rb = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 199) == 0);
      tick(c, rw, rb, r);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    coffee       = 1'b0;
    refill_water = 1'b0;
    refill_beans = 1'b0;
    test_reset();
    test_full_brew();
    test_busy_drop();
    test_last_dose();
    test_reset_mid_pour();
    test_refill_coffee_same();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
